// File: rtl/if_id_pipeline_reg_pkg.sv
// Shared IF/ID pipeline definitions: FSM encodings, NOP word and register-field positions.
// Imported by the IF/ID register and its helpers; no logic of its own.
package if_id_pipeline_reg_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } if_id_state_e;

   localparam int DEF_ADDR_BITS  = 5;
   localparam int DEF_DATA_WIDTH = 32;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] NOP_INSTR = 32'h0;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

endpackage

// File: rtl/if_id_pipeline_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Count updates one cycle after inc/clr; holds at MAX_VAL, no backpressure.
module sat_counter #(
   parameter int                 WIDTH   = 16,
   parameter logic [WIDTH-1:0]   MAX_VAL = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/if_id_pipeline_reg.sv
// IF/ID register: 1-cycle fetch-to-decode latch, holds on load-use stall, NOP on flush.
// Stall gates pc_write_en combinationally in the same cycle; enable=0 freezes everything.
module if_id_pipeline_reg
   import if_id_pipeline_reg_pkg::*;
#(
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_STALL  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  stall_flag,
   input  logic                  flush_flag,
   input  logic                  clear_stats,
   input  logic [DATA_WIDTH-1:0] pc_plus4_in,
   input  logic [DATA_WIDTH-1:0] instr_in,
   output logic                  pc_write_en,
   output logic [DATA_WIDTH-1:0] pc_plus4_out,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic                  valid_out,
   output logic [ADDR_BITS-1:0]  rs_out,
   output logic [ADDR_BITS-1:0]  rt_out,
   output logic [1:0]            state_o,
   output logic [CNT_WIDTH-1:0]  stall_count,
   output logic                  stall_timeout
);

   localparam int RUN_W = $clog2(MAX_STALL + 1);

   if_id_state_e     state_q, state_d;
   logic             stall_eff;
   logic             stall_inc;
   logic             run_clr;
   logic             timeout_hit;
   logic [RUN_W-1:0] stall_run;

   // A flush in the same cycle cancels the stall entirely
   assign stall_eff   = stall_flag & ~flush_flag;
   assign stall_inc   = enable & stall_eff;
   assign run_clr     = enable & ~stall_eff;
   assign pc_write_en = enable & ~stall_eff;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable) begin
         if (flush_flag) begin
            state_d = ST_FLUSH;
         end else if (stall_flag) begin
            state_d = ST_STALL;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_out    <= DATA_WIDTH'(NOP_INSTR);
         pc_plus4_out <= '0;
         valid_out    <= 1'b0;
      end else if (enable) begin
         if (flush_flag) begin
            instr_out    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4_out <= '0;
            valid_out    <= 1'b0;
         end else if (!stall_flag) begin
            instr_out    <= instr_in;
            pc_plus4_out <= pc_plus4_in;
            valid_out    <= 1'b1;
         end
      end
   end

   assign rs_out  = ADDR_BITS'(instr_out[RS_MSB:RS_LSB]);
   assign rt_out  = ADDR_BITS'(instr_out[RT_MSB:RT_LSB]);
   assign state_o = state_q;

   sat_counter #(
      .WIDTH   (RUN_W),
      .MAX_VAL (RUN_W'(MAX_STALL))
   ) u_stall_run (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (run_clr),
      .inc     (stall_inc),
      .count   (stall_run)
   );

   sat_counter #(
      .WIDTH   (CNT_WIDTH),
      .MAX_VAL ('1)
   ) u_stall_count (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear_stats),
      .inc     (stall_inc),
      .count   (stall_count)
   );

   // Fires on the edge that takes stall_run up to MAX_STALL
   assign timeout_hit = stall_inc && (stall_run == RUN_W'(MAX_STALL - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_timeout <= 1'b0;
      end else if (clear_stats) begin
         stall_timeout <= 1'b0;
      end else if (timeout_hit) begin
         stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Directed bench for the IF/ID register: expected post-edge results are queued per step and checked after the edge.
module tb_if_id_pipeline_reg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        stall_flag;
   logic        flush_flag;
   logic        clear_stats;
   logic [31:0] pc_plus4_in;
   logic [31:0] instr_in;
   logic        pc_write_en;
   logic [31:0] pc_plus4_out;
   logic [31:0] instr_out;
   logic        valid_out;
   logic [4:0]  rs_out;
   logic [4:0]  rt_out;
   logic [1:0]  state_o;
   logic [15:0] stall_count;
   logic        stall_timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic [1:0]  state;
      logic [15:0] count;
      logic        timeout;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   if_id_pipeline_reg #(
      .ADDR_BITS  (5),
      .DATA_WIDTH (32),
      .CNT_WIDTH  (16),
      .MAX_STALL  (4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .stall_flag    (stall_flag),
      .flush_flag    (flush_flag),
      .clear_stats   (clear_stats),
      .pc_plus4_in   (pc_plus4_in),
      .instr_in      (instr_in),
      .pc_write_en   (pc_write_en),
      .pc_plus4_out  (pc_plus4_out),
      .instr_out     (instr_out),
      .valid_out     (valid_out),
      .rs_out        (rs_out),
      .rt_out        (rt_out),
      .state_o       (state_o),
      .stall_count   (stall_count),
      .stall_timeout (stall_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input exp_t e);
      logic [31:0] ins;
      ins = e.instr;
      chk({e.tag, " instr"},   instr_out,     e.instr);
      chk({e.tag, " pc"},      pc_plus4_out,  e.pc);
      chk({e.tag, " valid"},   valid_out,     32'(e.valid));
      chk({e.tag, " rs"},      rs_out,        32'(ins[25:21]));
      chk({e.tag, " rt"},      rt_out,        32'(ins[20:16]));
      chk({e.tag, " state"},   state_o,       32'(e.state));
      chk({e.tag, " count"},   stall_count,   32'(e.count));
      chk({e.tag, " timeout"}, stall_timeout, 32'(e.timeout));
   endtask

   // Drive one cycle of inputs, check pc_write_en before the edge, registered outputs after it.
   task automatic step(input string tag, input logic en, input logic st, input logic fl,
                       input logic cl, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_valid,
                       input logic [1:0] e_state, input logic [15:0] e_count, input logic e_to);
      exp_t e;
      @(negedge clk);
      enable      = en;
      stall_flag  = st;
      flush_flag  = fl;
      clear_stats = cl;
      instr_in    = ins;
      pc_plus4_in = pc;
      e.tag = tag; e.instr = e_instr; e.pc = e_pc; e.valid = e_valid;
      e.state = e_state; e.count = e_count; e.timeout = e_to;
      exp_q.push_back(e);
      #1;
      chk({tag, " pc_write_en"}, 32'(pc_write_en), 32'(en & ~(st & ~fl)));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, observed none expected one entry", tag);
      end else begin
         chk_outputs(exp_q.pop_front());
      end
   endtask

   initial begin
      exp_t r;
      reset_n     = 1'b0;
      enable      = 1'b0;
      stall_flag  = 1'b0;
      flush_flag  = 1'b0;
      clear_stats = 1'b0;
      instr_in    = 32'h0;
      pc_plus4_in = 32'h0;
      #12;
      r.tag = "reset"; r.instr = 32'h0; r.pc = 32'h0; r.valid = 1'b0;
      r.state = 2'd0; r.count = 16'd0; r.timeout = 1'b0;
      chk_outputs(r);
      chk("reset pc_write_en", 32'(pc_write_en), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      //    tag          en st fl cl instr_in      pc       exp_instr     exp_pc  v  st  cnt to
      step("load1",      1, 0, 0, 0, 32'h8C220004, 32'd4,  32'h8C220004, 32'd4,  1, 0, 16'd0, 0);
      step("stallA1",    1, 1, 0, 0, 32'hAAAA0000, 32'd8,  32'h8C220004, 32'd4,  1, 1, 16'd1, 0);
      step("stallA2",    1, 1, 0, 0, 32'hBBBB0000, 32'd8,  32'h8C220004, 32'd4,  1, 1, 16'd2, 0);
      step("load2",      1, 0, 0, 0, 32'h012A4020, 32'd8,  32'h012A4020, 32'd8,  1, 0, 16'd2, 0);
      step("stallB1",    1, 1, 0, 0, 32'hCCCC0000, 32'd12, 32'h012A4020, 32'd8,  1, 1, 16'd3, 0);
      step("stallB2",    1, 1, 0, 0, 32'hCCCC0001, 32'd12, 32'h012A4020, 32'd8,  1, 1, 16'd4, 0);
      step("stallB3",    1, 1, 0, 0, 32'hCCCC0002, 32'd12, 32'h012A4020, 32'd8,  1, 1, 16'd5, 0);
      step("stallB4",    1, 1, 0, 0, 32'hCCCC0003, 32'd12, 32'h012A4020, 32'd8,  1, 1, 16'd6, 1);
      step("load3",      1, 0, 0, 0, 32'h00000020, 32'd12, 32'h00000020, 32'd12, 1, 0, 16'd6, 1);
      step("clr_stall",  1, 1, 0, 1, 32'hDDDD0000, 32'd16, 32'h00000020, 32'd12, 1, 1, 16'd0, 0);
      step("load4",      1, 0, 0, 0, 32'h8C430008, 32'd16, 32'h8C430008, 32'd16, 1, 0, 16'd0, 0);
      step("flush_stl",  1, 1, 1, 0, 32'h11111111, 32'd20, 32'h00000000, 32'd0,  0, 2, 16'd0, 0);
      step("flush2",     1, 0, 1, 0, 32'h11111112, 32'd20, 32'h00000000, 32'd0,  0, 2, 16'd0, 0);
      step("load5",      1, 0, 0, 0, 32'h22222222, 32'd20, 32'h22222222, 32'd20, 1, 0, 16'd0, 0);
      step("frozen",     0, 1, 0, 0, 32'h33333333, 32'd24, 32'h22222222, 32'd20, 1, 0, 16'd0, 0);
      step("stallC1",    1, 1, 0, 0, 32'h44444444, 32'd24, 32'h22222222, 32'd20, 1, 1, 16'd1, 0);

      // Asynchronous reset while stalled, well away from any clock edge
      #2;
      reset_n = 1'b0;
      #1;
      r.tag = "async_rst"; r.instr = 32'h0; r.pc = 32'h0; r.valid = 1'b0;
      r.state = 2'd0; r.count = 16'd0; r.timeout = 1'b0;
      chk_outputs(r);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL watchdog: observed no completion expected finish by 5000");
      $fatal(1, "timeout");
   end

endmodule
